// File: rtl/bin2text_seq.sv
// bin2text_seq: sequential double-dabble binary to signed ASCII decimal text.
// Define BIN2TEXT_LEADING_BLANK_EN to blank leading zero digits.
module bin2text_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic                     iSTART,
  input  logic                     iSIGNED,
  input  logic [WIDTH-1:0]         iVALUE,
  output logic                     oBUSY,
  output logic                     oDONE,
  output logic                     oOVF,
  output logic [0:(DIGITS+1)*8-1]  oTEXT
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = (DIGITS + 1) * 8;
  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;
  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [DIGITS*4-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d, sovf_q, sovf_d, ovf_q, ovf_d, done_q, done_d, co, nz, neg_in;
  logic [0:TW-1]       text_q, text_d;
  logic [DIGITS*8-1:0] dig_txt;
  assign neg_in = iSIGNED & iVALUE[WIDTH-1];
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
  end
  // Walk digits from the top; once a non-zero digit (or the last digit) is seen, show digits.
  always_comb begin
`ifdef BIN2TEXT_LEADING_BLANK_EN
    nz = 1'b0;
`else
    nz = 1'b1;
`endif
    dig_txt = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz = nz | (bcd_q[i*4 +: 4] != 4'd0) | (i == 0);
      dig_txt[i*8 +: 8] = nz ? {4'h3, bcd_q[i*4 +: 4]} : 8'd32;
    end
  end
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    sovf_d  = sovf_q;
    text_d  = text_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    co      = 1'b0;
    case (state_q)
      IDLE: if (iSTART) begin
        neg_d   = neg_in;
        mag_d   = neg_in ? ~iVALUE + 1'b1 : iVALUE;
        bcd_d   = '0;
        cnt_d   = CW'(WIDTH);
        sovf_d  = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {co, bcd_d, mag_d} = {adj, mag_q, 1'b0};
        sovf_d  = sovf_q | co;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? FORMAT : SHIFT;
      end
      FORMAT: begin
        text_d  = {neg_q ? 8'd45 : 8'd32, dig_txt};
        ovf_d   = sovf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sovf_q  <= 1'b0;
      text_q  <= {(DIGITS+1){8'd32}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      sovf_q  <= sovf_d;
      text_q  <= text_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end
  assign oBUSY = state_q != IDLE;
  assign oDONE = done_q;
  assign oOVF  = ovf_q;
  assign oTEXT = text_q;
endmodule

// File: tb/tb_bin2text_seq.sv
// tb_bin2text_seq: directed checks of bin2text_seq (DIGITS=5 and DIGITS=4 instances).
module tb_bin2text_seq;
  logic        iCLK = 1'b0, iRST_N = 1'b0, iSTART = 1'b0, iSIGNED = 1'b0;
  logic [15:0] iVALUE = '0;
  logic        oBUSY, oDONE, oOVF, oBUSY4, oDONE4, oOVF4;
  logic [0:47] oTEXT;
  logic [0:39] oTEXT4;
  int          n_run = 0, n_fail = 0, lat, d;
`ifdef BIN2TEXT_LEADING_BLANK_EN
  localparam logic [47:0] E_NEG1 = "-    1", E_ZERO = "     0", E_500 = "   500", E_7 = "     7", E_42 = "    42";
`else
  localparam logic [47:0] E_NEG1 = "-00001", E_ZERO = " 00000", E_500 = " 00500", E_7 = " 00007", E_42 = " 00042";
`endif
  bin2text_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iSIGNED(iSIGNED), .iVALUE(iVALUE),
    .oBUSY(oBUSY), .oDONE(oDONE), .oOVF(oOVF), .oTEXT(oTEXT)
  );
  bin2text_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iSIGNED(iSIGNED), .iVALUE(iVALUE),
    .oBUSY(oBUSY4), .oDONE(oDONE4), .oOVF(oOVF4), .oTEXT(oTEXT4)
  );
  always #5 iCLK = ~iCLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Called just after an active edge; returns in the oDONE cycle.
  task automatic convert(input logic s, input logic [15:0] v, input bit intr, output int l);
    iSTART = 1'b1; iSIGNED = s; iVALUE = v;
    @(posedge iCLK); #1;
    iSTART = 1'b0; iSIGNED = ~s; iVALUE = 16'h5a5a;
    chk("busy_after_start", oBUSY, 1);
    l = 0;
    for (int n = 1; n <= 40 && l == 0; n++) begin
      if (intr && n == 6) begin iSTART = 1'b1; iSIGNED = 1'b0; iVALUE = 16'd999; end
      @(posedge iCLK); #1;
      iSTART = 1'b0;
      if (oDONE) l = n;
    end
    chk("latency", l, 17);
    chk("busy_in_done", oBUSY, 0);
  endtask
  initial begin
    #12;
    chk("rst_busy", oBUSY, 0);
    chk("rst_done", oDONE, 0);
    chk("rst_ovf", oOVF, 0);
    chk("rst_text", oTEXT, "      ");
    @(posedge iCLK); #1 iRST_N = 1'b1;
    @(posedge iCLK); #1;
    convert(1'b0, 16'd12345, 1'b0, lat);
    chk("t12345", oTEXT, " 12345");
    chk("ovf12345", oOVF, 0);
    chk("d4_text", oTEXT4, " 2345");
    chk("d4_ovf", oOVF4, 1);
    @(posedge iCLK); #1;
    chk("done_one_cycle", oDONE, 0);
    chk("text_hold", oTEXT, " 12345");
    convert(1'b1, 16'hffff, 1'b0, lat);
    chk("neg1", oTEXT, E_NEG1);
    convert(1'b0, 16'hffff, 1'b0, lat);
    chk("u65535", oTEXT, " 65535");
    chk("d4_65535", oTEXT4, " 5535");
    convert(1'b1, 16'h8000, 1'b0, lat);
    chk("most_neg", oTEXT, "-32768");
    chk("most_neg_ovf", oOVF, 0);
    chk("d4_most_neg_ovf", oOVF4, 1);
    convert(1'b1, 16'd0, 1'b0, lat);
    chk("zero", oTEXT, E_ZERO);
    convert(1'b0, 16'd500, 1'b1, lat);
    chk("busy_ignore", oTEXT, E_500);
    convert(1'b0, 16'd7, 1'b0, lat);
    chk("back_to_back", oTEXT, E_7);
    d = 0;
    repeat (20) begin @(posedge iCLK); #1; d += int'(oDONE); end
    chk("no_queued_done", d, 0);
    iSTART = 1'b1; iSIGNED = 1'b0; iVALUE = 16'd12345;
    @(posedge iCLK); #1 iSTART = 1'b0;
    repeat (8) @(posedge iCLK);
    #1 iRST_N = 1'b0;
    #1;
    chk("mid_rst_busy", oBUSY, 0);
    chk("mid_rst_done", oDONE, 0);
    chk("mid_rst_text", oTEXT, "      ");
    chk("mid_rst_ovf", oOVF, 0);
    @(posedge iCLK); #1 iRST_N = 1'b1;
    d = 0;
    repeat (20) begin @(posedge iCLK); #1; d += int'(oDONE); end
    chk("abort_no_done", d, 0);
    convert(1'b0, 16'd42, 1'b0, lat);
    chk("after_rst", oTEXT, E_42);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
